// File: rtl/core_ctrl.sv
// Job sequencer for the systolic core: per kernel position it loads weights, gaps,
// loads activations, executes, then drains the output FIFO into psum memory.
module core_ctrl #(
  parameter int unsigned col     = 8,
  parameter int unsigned len_nij = 36,
  parameter int unsigned len_kij = 9,
  parameter int unsigned gap_cyc = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic [3:0]  kij,
  output logic        busy,
  output logic        done
);

  localparam int CW = 16;
  // pmem CEN/WEN are bits 32/31 and xmem CEN/WEN are bits 19/18; everything else low
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
  localparam logic [CW-1:0] COL_C   = CW'(col);
  localparam logic [CW-1:0] KLD_END = CW'(3 * col - 1);
  localparam logic [CW-1:0] GAP_END = CW'(gap_cyc - 1);
  localparam logic [CW-1:0] NIJ_C   = CW'(len_nij);
  localparam logic [CW-1:0] NIJ_M1  = CW'(len_nij - 1);
  localparam logic [3:0]    KIJ_END = 4'(len_kij - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WL0, S_KLD, S_GAP, S_AL0, S_EXE, S_ORD, S_FIN
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   rd_cnt, rd_n;
  logic [CW-1:0]   wr_cnt, wr_n;
  logic [3:0]      kij_n;
  logic [33:0]     inst_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      kij    <= '0;
      inst   <= IDLE_WORD;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rd_cnt <= rd_n;
      wr_cnt <= wr_n;
      kij    <= kij_n;
      inst   <= inst_d;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = rd_cnt;
    wr_n    = wr_cnt;
    kij_n   = kij;
    inst_d  = IDLE_WORD;

    // a read on the output bus this cycle becomes a pmem write in the next word
    if (inst[6]) begin
      inst_d[32]    = 1'b0;
      inst_d[31]    = 1'b0;
      inst_d[30:20] = 11'(32'(kij) * len_nij + 32'(wr_cnt));
      wr_n          = wr_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WL0;
          kij_n   = '0;
          cnt_n   = '0;
        end
      end
      S_WL0: begin
        if (cnt < COL_C) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = 11'(32'h400 + 32'(kij) * col + 32'(cnt));
        end
        if (cnt != '0) inst_d[2] = 1'b1;
        if (cnt == COL_C) begin
          state_n = S_KLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_KLD: begin
        inst_d[0] = 1'b1;
        if (cnt < COL_C) inst_d[3] = 1'b1;
        if (cnt == KLD_END) begin
          state_n = S_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_END) begin
          state_n = S_AL0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_AL0: begin
        if (cnt < NIJ_C) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = 11'(cnt);
        end
        if (cnt != '0) inst_d[2] = 1'b1;
        if (cnt == NIJ_C) begin
          state_n = S_EXE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_EXE: begin
        inst_d[1] = 1'b1;
        inst_d[3] = 1'b1;
        if (cnt == NIJ_M1) begin
          state_n = S_ORD;
          cnt_n   = '0;
          rd_n    = '0;
          wr_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_ORD: begin
        if (rd_cnt < NIJ_C) begin
          inst_d[6] = ofifo_valid;
          rd_n      = rd_cnt + CW'(ofifo_valid);
        end
        // leave once the final write has been issued; stall otherwise
        if (inst[6] && wr_cnt == NIJ_M1) begin
          cnt_n = '0;
          if (kij == KIJ_END) begin
            state_n = S_FIN;
          end else begin
            state_n = S_WL0;
            kij_n   = kij + 1'b1;
          end
        end
      end
      S_FIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized bench for core_ctrl: a phase-level job model predicts the instruction
// stream, kij, busy and done cycle by cycle, plus the pmem write address order.
module tb_core_ctrl;

  localparam int COL = 8;
  localparam int NIJ = 36;
  localparam int LK  = 9;
  localparam int GAP = 13;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam int VMAX = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic [3:0]  kij;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  bit          vv[VMAX];
  logic [33:0] exp_inst[$];
  int          exp_kij[$];
  int          fin_idx;
  int          first_done;

  core_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .kij(kij), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [33:0] w, input int k);
    exp_inst.push_back(w);
    exp_kij.push_back(k);
  endtask

  // Expected word for every cycle the controller is busy, built phase by phase
  task automatic build_model();
    logic [33:0] w;
    int reads, writes;
    bit prev, cur;
    exp_inst.delete();
    exp_kij.delete();
    for (int kk = 0; kk < LK; kk++) begin
      for (int c = 0; c <= COL; c++) begin
        w = IDLE_W;
        if (c < COL) begin w[19] = 1'b0; w[17:7] = 11'(1024 + kk * COL + c); end
        if (c >= 1) w[2] = 1'b1;
        push(w, kk);
      end
      for (int c = 0; c < 3 * COL; c++) begin
        w = IDLE_W; w[0] = 1'b1;
        if (c < COL) w[3] = 1'b1;
        push(w, kk);
      end
      for (int c = 0; c < GAP; c++) push(IDLE_W, kk);
      for (int c = 0; c <= NIJ; c++) begin
        w = IDLE_W;
        if (c < NIJ) begin w[19] = 1'b0; w[17:7] = 11'(c); end
        if (c >= 1) w[2] = 1'b1;
        push(w, kk);
      end
      for (int c = 0; c < NIJ; c++) begin
        w = IDLE_W; w[1] = 1'b1; w[3] = 1'b1;
        push(w, kk);
      end
      reads = 0; writes = 0; prev = 1'b0;
      while (writes < NIJ && exp_inst.size() < VMAX - 16) begin
        w = IDLE_W; cur = 1'b0;
        if (reads < NIJ && vv[exp_inst.size()]) begin w[6] = 1'b1; cur = 1'b1; reads++; end
        if (prev) begin
          w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(kk * NIJ + writes);
          writes++;
        end
        push(w, kk);
        prev = cur;
      end
    end
    push(IDLE_W, LK - 1);
    fin_idx = exp_inst.size() - 1;
  endtask

  // mode 0: valid tied high, 1: random with stalls, 2: toggling 1,0,1,0
  task automatic run_job(input int mode, input bit kld_pulse, input int abort_k);
    int next_addr, nwr, ndone;
    logic [33:0] e;
    for (int i = 0; i < VMAX; i++)
      vv[i] = (mode == 0) ? 1'b1 : (mode == 2) ? ((i % 2) == 0) : ($urandom_range(0, 2) == 0);
    build_model();
    next_addr = 0; nwr = 0; ndone = 0; first_done = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= fin_idx + 1; k++) begin
      ofifo_valid = vv[k];
      start = kld_pulse && (k == 12);
      if (k == abort_k) begin reset = 1'b1; start = 1'b1; end
      @(negedge clk);
      e = (k == 0) ? IDLE_W : exp_inst[k - 1];
      checks++;
      if (inst !== e) begin errors++; $display("FAIL inst k=%0d got %h exp %h", k, inst, e); end
      if (k <= fin_idx) begin
        checks++;
        if (kij !== 4'(exp_kij[k])) begin errors++; $display("FAIL kij k=%0d got %0d exp %0d", k, kij, exp_kij[k]); end
      end
      checks++;
      if (busy !== (k <= fin_idx)) begin errors++; $display("FAIL busy k=%0d got %b exp %b", k, busy, k <= fin_idx); end
      checks++;
      if (done !== (k == fin_idx)) begin errors++; $display("FAIL done k=%0d got %b exp %b", k, done, k == fin_idx); end
      if (done === 1'b1) begin ndone++; if (first_done < 0) first_done = k; end
      if (inst[32] === 1'b0 && inst[31] === 1'b0) begin
        checks++;
        if (int'(inst[30:20]) != next_addr) begin
          errors++; $display("FAIL pmem_addr got %0d exp %0d", inst[30:20], next_addr);
        end
        next_addr++; nwr++;
      end
      @(posedge clk); #1;
      if (k == abort_k) begin
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (inst !== IDLE_W || kij !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL abort got inst=%h kij=%0d busy=%b done=%b exp inst=%h kij=0 busy=0 done=0",
                   inst, kij, busy, done, IDLE_W);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    checks++;
    if (nwr != LK * NIJ) begin errors++; $display("FAIL pmem_count got %0d exp %0d", nwr, LK * NIJ); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL done_pulses got %0d exp 1", ndone); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; ofifo_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (inst !== IDLE_W || kij !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got inst=%h kij=%0d busy=%b done=%b exp inst=%h kij=0 busy=0 done=0",
                 inst, kij, busy, done, IDLE_W);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (inst !== IDLE_W || busy !== 1'b0) begin
        errors++; $display("FAIL idle_after_reset got inst=%h busy=%b exp inst=%h busy=0", inst, busy, IDLE_W);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_job();
    run_job(0, 1'b0, -1);
    checks++;
    if (first_done != 1404) begin errors++; $display("FAIL done_latency got %0d exp 1404", first_done); end
  endtask

  task automatic test_toggle_valid();
    run_job(2, 1'b0, -1);
  endtask

  task automatic test_random_stall();
    run_job(1, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    run_job(1, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    // kij=4 EXE begins at 4*156 + 83 = 707; abort a few cycles in
    run_job(0, 1'b0, 712);
    repeat (2) @(posedge clk);
    #1;
    run_job(1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_job(1, 1'b0, -1);
    run_job(2, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_toggle_valid();
    test_random_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
